// File: rtl/lift_pkg.sv
// Shared definitions for the three-floor lift call scheduler: floor encodings,
// scheduler state encoding and a floor-to-bitmask helper.
package lift_pkg;

    localparam int NUM_FLOORS = 3;
    localparam int FLOOR_W    = 2;

    typedef logic [FLOOR_W-1:0] floor_t;

    localparam floor_t FLOOR0 = 2'd0;
    localparam floor_t FLOOR1 = 2'd1;
    localparam floor_t FLOOR2 = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_REQ,
        ST_MOVING,
        ST_DOOR
    } state_t;

    // One-hot mask of a floor; the invalid encoding 3 maps to an empty mask.
    function automatic logic [NUM_FLOORS-1:0] floor_mask(input floor_t f);
        logic [NUM_FLOORS-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (floor_t'(i) == f) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/lift_scan_select.sv
// Combinational sweep selector: nearest pending floor in the current direction,
// falling back to the opposite direction (and reporting the flip) when none.
module lift_scan_select
    import lift_pkg::*;
(
    input  logic [NUM_FLOORS-1:0] pending,
    input  floor_t                cur_floor,
    input  logic                  dir_up,
    output logic                  found,
    output floor_t                next_floor,
    output logic                  flip_dir
);

    logic   found_up;
    logic   found_dn;
    floor_t up_floor;
    floor_t dn_floor;

    // Scan order makes the last hit the nearest one on each side.
    always_comb begin
        found_up = 1'b0;
        up_floor = cur_floor;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (floor_t'(i) > cur_floor)) begin
                found_up = 1'b1;
                up_floor = floor_t'(i);
            end
        end
        found_dn = 1'b0;
        dn_floor = cur_floor;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && (floor_t'(i) < cur_floor)) begin
                found_dn = 1'b1;
                dn_floor = floor_t'(i);
            end
        end
    end

    always_comb begin
        found      = found_up | found_dn;
        next_floor = cur_floor;
        flip_dir   = 1'b0;
        if (dir_up) begin
            if (found_up) begin
                next_floor = up_floor;
            end else if (found_dn) begin
                next_floor = dn_floor;
                flip_dir   = 1'b1;
            end
        end else begin
            if (found_dn) begin
                next_floor = dn_floor;
            end else if (found_up) begin
                next_floor = up_floor;
                flip_dir   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lift_call_scheduler.sv
// Lift call scheduler: latches floor calls, sweeps targets up/down, handshakes
// moves with the motion controller and times the door; all outputs registered.
module lift_call_scheduler
    import lift_pkg::*;
#(
    parameter int DOOR_CYCLES = 8
)(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_FLOORS-1:0] call,
    input  floor_t                cur_floor,
    output logic                  move_req,
    input  logic                  move_ack,
    input  logic                  arrived,
    output floor_t                target_floor,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] call_pending,
    output logic                  dir_up,
    output logic                  busy
);

    localparam int               CNT_W    = $clog2(DOOR_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DOOR_CYCLES);

    state_t                state_q, state_d;
    floor_t                target_q, target_d;
    logic                  dir_up_q, dir_up_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  move_req_q, move_req_d;
    logic                  door_open_q, door_open_d;
    logic                  busy_q, busy_d;

    logic                  scan_found;
    floor_t                scan_floor;
    logic                  scan_flip;
    logic [NUM_FLOORS-1:0] cur_mask;
    logic [NUM_FLOORS-1:0] call_set;

    lift_scan_select u_scan (
        .pending    (pending_q),
        .cur_floor  (cur_floor),
        .dir_up     (dir_up_q),
        .found      (scan_found),
        .next_floor (scan_floor),
        .flip_dir   (scan_flip)
    );

    assign cur_mask = floor_mask(cur_floor);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            target_q    <= FLOOR0;
            dir_up_q    <= 1'b1;
            pending_q   <= '0;
            cnt_q       <= '0;
            move_req_q  <= 1'b0;
            door_open_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            dir_up_q    <= dir_up_d;
            pending_q   <= pending_d;
            cnt_q       <= cnt_d;
            move_req_q  <= move_req_d;
            door_open_q <= door_open_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        dir_up_d = dir_up_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|pending_q) state_d = ST_SELECT;
            end
            ST_SELECT: begin
                // An invalid floor reading holds the scheduler here.
                if (cur_floor <= FLOOR2) begin
                    if (|(pending_q & cur_mask)) begin
                        state_d  = ST_DOOR;
                        target_d = cur_floor;
                        cnt_d    = CNT_LOAD;
                    end else if (scan_found) begin
                        state_d  = ST_REQ;
                        target_d = scan_floor;
                        dir_up_d = dir_up_q ^ scan_flip;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_REQ: begin
                if (move_ack) state_d = ST_MOVING;
            end
            ST_MOVING: begin
                if (arrived) begin
                    state_d = ST_DOOR;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_DOOR: begin
                if (|(call & cur_mask)) begin
                    cnt_d = CNT_LOAD;
                end else if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = (|pending_q) ? ST_SELECT : ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Calls at the floor whose door is open are served by the reopen, not latched.
        call_set  = call & ~((state_q == ST_DOOR) ? cur_mask : '0);
        pending_d = pending_q | call_set;
        if ((state_d == ST_DOOR) && (state_q != ST_DOOR)) begin
            pending_d = pending_d & ~floor_mask(target_d);
        end
    end

    always_comb begin
        move_req_d  = (state_d == ST_REQ);
        door_open_d = (state_d == ST_DOOR);
        busy_d      = (state_d != ST_IDLE);
    end

    assign move_req     = move_req_q;
    assign target_floor = target_q;
    assign door_open    = door_open_q;
    assign call_pending = pending_q;
    assign dir_up       = dir_up_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_lift_call_scheduler.sv
// Directed bench for lift_call_scheduler: expected move/door events are queued
// as stimulus is issued and a monitor pops and compares them as the DUT shows them.
module tb_lift_call_scheduler;

    logic       clk;
    logic       reset_n;
    logic [2:0] call;
    logic [1:0] cur_floor;
    logic       move_req;
    logic       move_ack;
    logic       arrived;
    logic [1:0] target_floor;
    logic       door_open;
    logic [2:0] call_pending;
    logic       dir_up;
    logic       busy;

    typedef struct {
        bit         is_door;
        logic [1:0] floor;
        int         len;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_err = 0;

    lift_call_scheduler #(.DOOR_CYCLES(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .call         (call),
        .cur_floor    (cur_floor),
        .move_req     (move_req),
        .move_ack     (move_ack),
        .arrived      (arrived),
        .target_floor (target_floor),
        .door_open    (door_open),
        .call_pending (call_pending),
        .dir_up       (dir_up),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t reached, required finish before 200000", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_ev(input bit is_door, input logic [1:0] floor, input int len);
        ev_t e;
        e.is_door = is_door;
        e.floor   = floor;
        e.len     = len;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_move(input int budget);
        int n = 0;
        while (!move_req && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!move_req) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_move: move_req=0 after %0d cycles, expected 1", budget);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", int'(busy), 0);
    endtask

    task automatic pulse_call(input logic [2:0] c);
        call = c;
        tick(1);
        call = 3'b000;
    endtask

    // Motion controller model: accept after ack_wait cycles, arrive after travel.
    task automatic serve(input int ack_wait, input int travel, input logic [1:0] dest);
        wait_move(40);
        tick(ack_wait);
        move_ack = 1'b1;
        tick(1);
        move_ack = 1'b0;
        check("move_req_drop_after_ack", int'(move_req), 0);
        check("busy_moving", int'(busy), 1);
        tick(travel);
        cur_floor = dest;
        arrived   = 1'b1;
        tick(1);
        arrived = 1'b0;
    endtask

    // Scoreboard monitor
    initial begin
        logic       prev_mr;
        logic       prev_door;
        logic       mv_bad;
        logic [1:0] mv_target;
        logic [1:0] door_floor;
        int         door_len;
        ev_t        e;
        prev_mr    = 1'b0;
        prev_door  = 1'b0;
        mv_bad     = 1'b0;
        mv_target  = 2'd0;
        door_floor = 2'd0;
        door_len   = 0;
        forever begin
            @(negedge clk);
            if (move_req && !prev_mr) begin
                mv_target = target_floor;
                mv_bad    = 1'b0;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_move: got move_req to floor %0d, expected no event", target_floor);
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind_move", 0, int'(e.is_door));
                    check("move_target", int'(target_floor), int'(e.floor));
                end
            end else if (move_req && (target_floor != mv_target)) begin
                mv_bad = 1'b1;
            end
            if (!move_req && prev_mr) check("move_target_stable", int'(mv_bad), 0);
            if (door_open && !prev_door) begin
                door_len   = 0;
                door_floor = target_floor;
            end
            if (door_open) door_len++;
            if (!door_open && prev_door) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_door: got door at floor %0d, expected no event", door_floor);
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind_door", 1, int'(e.is_door));
                    check("door_floor", int'(door_floor), int'(e.floor));
                    check("door_len", door_len, e.len);
                end
            end
            prev_mr   = move_req;
            prev_door = door_open;
        end
    end

    initial begin
        reset_n   = 1'b0;
        call      = 3'b000;
        cur_floor = 2'd0;
        move_ack  = 1'b0;
        arrived   = 1'b0;
        tick(3);
        check("rst_move_req", int'(move_req), 0);
        check("rst_door_open", int'(door_open), 0);
        check("rst_target", int'(target_floor), 0);
        check("rst_pending", int'(call_pending), 0);
        check("rst_dir_up", int'(dir_up), 1);
        check("rst_busy", int'(busy), 0);
        reset_n = 1'b1;
        tick(2);

        // Single call from floor 0 to floor 2, with latency checks
        push_ev(0, 2'd2, 0);
        push_ev(1, 2'd2, 8);
        call = 3'b100;
        tick(1);
        call = 3'b000;
        check("a_pending_latched", int'(call_pending), 4);
        check("a_no_req_edge_n", int'(move_req), 0);
        tick(1);
        check("a_no_req_edge_n1", int'(move_req), 0);
        check("a_busy_select", int'(busy), 1);
        tick(1);
        check("a_req_edge_n2", int'(move_req), 1);
        check("a_target", int'(target_floor), 2);
        serve(0, 3, 2'd2);
        check("a_pending_cleared", int'(call_pending), 0);
        wait_idle(30);
        check("a_door_closed", int'(door_open), 0);
        check("a_dir_up", int'(dir_up), 1);

        // Floor 1 heading up with calls at 0 and 2: serve 2, then reverse to 0
        cur_floor = 2'd1;
        push_ev(0, 2'd2, 0);
        push_ev(1, 2'd2, 8);
        push_ev(0, 2'd0, 0);
        push_ev(1, 2'd0, 8);
        pulse_call(3'b101);
        serve(1, 2, 2'd2);
        check("b_pending_after_first", int'(call_pending), 1);
        tick(1);
        wait_move(40);
        check("b_dir_reversed", int'(dir_up), 0);
        check("b_second_target", int'(target_floor), 0);
        serve(0, 3, 2'd0);
        wait_idle(30);
        check("b_pending_empty", int'(call_pending), 0);

        // Call at the current floor: door only, no move
        cur_floor = 2'd1;
        push_ev(1, 2'd1, 8);
        pulse_call(3'b010);
        tick(1);
        check("c_busy", int'(busy), 1);
        check("c_no_move", int'(move_req), 0);
        wait_idle(30);
        check("c_dir_kept", int'(dir_up), 0);

        // Door reopen at floor 2 when 3 cycles remain
        push_ev(0, 2'd2, 0);
        push_ev(1, 2'd2, 14);
        pulse_call(3'b100);
        serve(0, 2, 2'd2);
        check("d_door_open", int'(door_open), 1);
        tick(5);
        call = 3'b100;
        tick(1);
        call = 3'b000;
        check("d_call_not_latched", int'(call_pending), 0);
        tick(3);
        check("d_door_still_open", int'(door_open), 1);
        wait_idle(40);
        check("d_dir_up", int'(dir_up), 1);

        // Withheld acknowledge with a stray arrived pulse
        push_ev(0, 2'd0, 0);
        push_ev(1, 2'd0, 8);
        pulse_call(3'b001);
        wait_move(10);
        for (int i = 0; i < 20; i++) begin
            arrived = (i == 10);
            tick(1);
        end
        arrived = 1'b0;
        check("e_req_held", int'(move_req), 1);
        check("e_target_held", int'(target_floor), 0);
        check("e_no_door", int'(door_open), 0);
        check("e_dir_down", int'(dir_up), 0);
        serve(0, 2, 2'd0);
        wait_idle(30);

        // Asynchronous reset during MOVING with calls outstanding
        push_ev(0, 2'd2, 0);
        pulse_call(3'b100);
        wait_move(10);
        move_ack = 1'b1;
        tick(1);
        move_ack = 1'b0;
        tick(2);
        pulse_call(3'b010);
        check("f_pending_before_rst", int'(call_pending), 6);
        check("f_busy_before_rst", int'(busy), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("f_rst_move_req", int'(move_req), 0);
        check("f_rst_pending", int'(call_pending), 0);
        check("f_rst_busy", int'(busy), 0);
        check("f_rst_dir_up", int'(dir_up), 1);
        check("f_rst_door", int'(door_open), 0);
        tick(2);
        reset_n = 1'b1;
        tick(20);
        check("f_no_dispatch", int'(move_req), 0);
        check("f_idle_after", int'(busy), 0);
        check("f_pending_after", int'(call_pending), 0);

        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lift_call_scheduler.md
LIFT_CALL_SCHEDULER -- requirements
Module: lift_call_scheduler

Interface
REQ-001 SHALL have parameter: DOOR_CYCLES, 8, number of cycles door_open is held per stop (legal range 2..255).
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: call  in  3  per-floor call buttons, level, bit i = floor i.
REQ-005 SHALL have port: cur_floor  in  2  latched current floor from the motion controller (0..2).
REQ-006 SHALL have port: move_req  out  1  request to the motion controller to travel to target_floor.
REQ-007 SHALL have port: move_ack  in  1  motion controller accepts move_req.
REQ-008 SHALL have port: arrived  in  1  one-cycle pulse: motion controller reached target_floor.
REQ-009 SHALL have port: target_floor  out  2  floor being served; stable whenever move_req=1.
REQ-010 SHALL have port: door_open  out  1  door command.
REQ-011 SHALL have port: call_pending  out  3  registered call latches (button lamps).
REQ-012 SHALL have port: dir_up  out  1  current sweep direction (1 = up).
REQ-013 SHALL have port: busy  out  1  high in every state except IDLE.

Function
REQ-014 SHALL implement states IDLE, SELECT, REQ, MOVING, DOOR; all outputs registered.
REQ-015 SHALL set call_pending[i] when call[i]=1, except in DOOR with cur_floor=i, where the call is not latched.
REQ-016 SHALL clear call_pending[target_floor] on the edge entering DOOR; a simultaneous set and clear on the same bit resolves to clear.
REQ-017 IDLE: SHALL go to SELECT on the first edge where call_pending is non-zero.
REQ-018 SELECT: if call_pending[cur_floor]=1, SHALL go to DOOR with target_floor=cur_floor and no move request.
REQ-019 SELECT: SHALL otherwise pick the nearest pending floor in the dir_up direction.
REQ-020 SELECT: if no pending floor lies in the dir_up direction, SHALL invert dir_up and pick the nearest pending floor in the new direction.
REQ-021 SELECT: SHALL load target_floor and go to REQ; if nothing is pending, SHALL go to IDLE.
REQ-022 REQ: SHALL hold move_req=1 and target_floor constant until move_ack=1, then go to MOVING with move_req=0 on the next cycle.
REQ-023 MOVING: SHALL wait for arrived=1, then go to DOOR.
REQ-024 SHALL ignore move_ack outside REQ and arrived outside MOVING.
REQ-025 DOOR: SHALL hold door_open=1 for exactly DOOR_CYCLES cycles using a down-counter of width clog2(DOOR_CYCLES+1).
REQ-026 DOOR: call[cur_floor]=1 SHALL reload the counter to DOOR_CYCLES (door reopen).
REQ-027 DOOR: when the counter expires, SHALL go to SELECT if any call is pending, else to IDLE.
REQ-028 Latency: a call at a non-current floor first sampled at edge N in IDLE SHALL produce move_req=1 after edge N+2.
REQ-029 If cur_floor=3 (invalid), SELECT SHALL stall and not dispatch until cur_floor is valid.

Reset
REQ-030 On reset_n=0, SHALL immediately force state=IDLE, move_req=0, door_open=0, target_floor=0, call_pending=0, dir_up=1, busy=0, and counter=0.
REQ-031 Reset asserted mid-move or mid-door SHALL drop move_req and door_open asynchronously, discard all pending calls, and leave no pending request after release.
REQ-032 SHALL sample call and handshake inputs only from the first rising edge after reset_n deasserts.

Structure
REQ-033 Shared package lift_pkg SHALL hold the floor encodings FLOOR0=0, FLOOR1=1, FLOOR2=2, NUM_FLOORS=3, and the scheduler state enum.
REQ-034 SHALL instantiate one combinational sub-module, lift_scan_select, that computes the next target and the direction flip from (call_pending, cur_floor, dir_up).
REQ-035 SHALL keep all sequential logic in lift_call_scheduler.

Verification
REQ-036 Scenario: cur_floor=0, call=3'b100 for one cycle -> move_req=1 with target_floor=2 two edges later; move_ack -> MOVING; arrived -> door_open high for 8 cycles; call_pending=0; IDLE.
REQ-037 Scenario: cur_floor=1, dir_up=1, pending={0,2} -> target_floor=2 first; after the door cycle, dir_up=0 and target_floor=0.
REQ-038 Scenario: idle at floor 1, call=3'b010 -> door_open for 8 cycles, move_req never asserted.
REQ-039 Scenario: in DOOR at floor 2 with counter=3, call[2]=1 -> door_open lasts 8 more cycles; call_pending[2] stays 0.
REQ-040 Scenario: move_ack withheld for 20 cycles -> move_req and target_floor stable throughout; arrived pulse in REQ is ignored.
REQ-041 Scenario: reset_n pulsed low in MOVING -> move_req=0 and call_pending=0 immediately; no dispatch after release until a new call.
